// File: rtl/ex_stage_reg.sv
// rtl/ex_stage_reg.sv - EX/MEM pipeline register with stall, flush and exception bubbles
module ex_stage_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic        alu_of,
  input  logic        stall,
  input  logic        flush,
  input  logic        int_detect,
  input  logic [29:0] id_pc,
  input  logic        id_en_,
  input  logic        id_br_flag,
  input  logic [1:0]  id_mem_op,
  input  logic [31:0] id_mem_wr_data,
  input  logic [1:0]  id_ctrl_op,
  input  logic [4:0]  id_dst_addr,
  input  logic        id_gpr_we_,
  input  logic [2:0]  id_exp_code,
  output logic [29:0] ex_pc,
  output logic        ex_en_,
  output logic        ex_br_flag,
  output logic [1:0]  ex_mem_op,
  output logic [31:0] ex_mem_wr_data,
  output logic [1:0]  ex_ctrl_op,
  output logic [4:0]  ex_dst_addr,
  output logic        ex_gpr_we_,
  output logic [2:0]  ex_exp_code,
  output logic [31:0] ex_out
);

  localparam logic [1:0] MEM_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_NOP = 2'd0;
  localparam logic [2:0] EXP_NO_EXP  = 3'd0;
  localparam logic [2:0] EXP_EXT_INT = 3'd1;
  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  always_ff @(posedge clk) begin
    if (reset || (!stall && flush)) begin
      ex_pc          <= '0;
      ex_en_         <= 1'b1;
      ex_br_flag     <= 1'b0;
      ex_mem_op      <= MEM_OP_NOP;
      ex_mem_wr_data <= '0;
      ex_ctrl_op     <= CTRL_OP_NOP;
      ex_dst_addr    <= '0;
      ex_gpr_we_     <= 1'b1;
      ex_exp_code    <= EXP_NO_EXP;
      ex_out         <= '0;
    end else if (!stall) begin
      ex_pc      <= id_pc;
      ex_en_     <= id_en_;
      ex_br_flag <= id_br_flag;
      if (int_detect || alu_of) begin
        // Exception bubble: keep the PC for EPC, kill memory access and writeback.
        ex_mem_op      <= MEM_OP_NOP;
        ex_mem_wr_data <= '0;
        ex_ctrl_op     <= CTRL_OP_NOP;
        ex_dst_addr    <= '0;
        ex_gpr_we_     <= 1'b1;
        ex_exp_code    <= int_detect ? EXP_EXT_INT : EXP_OVERFLOW;
        ex_out         <= '0;
      end else begin
        ex_mem_op      <= id_mem_op;
        ex_mem_wr_data <= id_mem_wr_data;
        ex_ctrl_op     <= id_ctrl_op;
        ex_dst_addr    <= id_dst_addr;
        ex_gpr_we_     <= id_gpr_we_;
        ex_exp_code    <= id_exp_code;
        ex_out         <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_reg.sv
// tb/tb_ex_stage_reg.sv - self-checking bench for ex_stage_reg
module tb_ex_stage_reg;

  logic        clk = 1'b0;
  logic        reset, alu_of, stall, flush, int_detect;
  logic [31:0] alu_out, id_mem_wr_data;
  logic [29:0] id_pc;
  logic        id_en_, id_br_flag, id_gpr_we_;
  logic [1:0]  id_mem_op, id_ctrl_op;
  logic [4:0]  id_dst_addr;
  logic [2:0]  id_exp_code;
  logic [29:0] ex_pc;
  logic        ex_en_, ex_br_flag, ex_gpr_we_;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;

  ex_stage_reg dut (
    .clk(clk), .reset(reset), .alu_out(alu_out), .alu_of(alu_of), .stall(stall),
    .flush(flush), .int_detect(int_detect), .id_pc(id_pc), .id_en_(id_en_),
    .id_br_flag(id_br_flag), .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
    .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
    .id_exp_code(id_exp_code), .ex_pc(ex_pc), .ex_en_(ex_en_), .ex_br_flag(ex_br_flag),
    .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op),
    .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
    .ex_out(ex_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] pc;
    logic        en_;
    logic        br;
    logic [1:0]  mem_op;
    logic [31:0] wr_data;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst;
    logic        we_;
    logic [2:0]  exp;
    logic [31:0] out;
  } stage_t;

  localparam stage_t BUBBLE = '{pc: 30'd0, en_: 1'b1, br: 1'b0, mem_op: 2'd0, wr_data: 32'd0,
                                ctrl_op: 2'd0, dst: 5'd0, we_: 1'b1, exp: 3'd0, out: 32'd0};

  stage_t model;
  bit     model_valid = 1'b0;
  int     errors = 0;
  int     checks = 0;

  // Reference: what MEM must see next, from the stage's rules.
  always @(posedge clk) begin
    stage_t nxt;
    nxt = model;
    if (reset) begin
      nxt = BUBBLE;
      model_valid = 1'b1;
    end else if (stall) begin
      nxt = model;
    end else if (flush) begin
      nxt = BUBBLE;
    end else begin
      nxt = '{pc: id_pc, en_: id_en_, br: id_br_flag, mem_op: id_mem_op,
              wr_data: id_mem_wr_data, ctrl_op: id_ctrl_op, dst: id_dst_addr,
              we_: id_gpr_we_, exp: id_exp_code, out: alu_out};
      if (int_detect || alu_of) begin
        nxt.mem_op = 2'd0; nxt.wr_data = 32'd0; nxt.ctrl_op = 2'd0;
        nxt.dst = 5'd0; nxt.we_ = 1'b1; nxt.out = 32'd0;
        nxt.exp = int_detect ? 3'd1 : 3'd3;
      end
    end
    model = nxt;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      stage_t act;
      act = '{pc: ex_pc, en_: ex_en_, br: ex_br_flag, mem_op: ex_mem_op,
              wr_data: ex_mem_wr_data, ctrl_op: ex_ctrl_op, dst: ex_dst_addr,
              we_: ex_gpr_we_, exp: ex_exp_code, out: ex_out};
      checks++;
      if (act !== model) begin
        errors++;
        $display("FAIL model_cmp @%0t actual=%h required=%h", $time, act, model);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [29:0] pc, input logic en_, input logic br,
                          input logic [1:0] mop, input logic [31:0] wd, input logic [1:0] cop,
                          input logic [4:0] dst, input logic we_, input logic [2:0] ec,
                          input logic [31:0] alu);
    id_pc = pc; id_en_ = en_; id_br_flag = br; id_mem_op = mop; id_mem_wr_data = wd;
    id_ctrl_op = cop; id_dst_addr = dst; id_gpr_we_ = we_; id_exp_code = ec; alu_out = alu;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; int_detect = 1'b0; alu_of = 1'b0;
    set_data(30'h3ff, 1'b0, 1'b1, 2'd2, 32'hcafef00d, 2'd1, 5'd9, 1'b0, 3'd5, 32'h77);
    tick();
    check("rst_en_", ex_en_, 1);
    check("rst_gpr_we_", ex_gpr_we_, 1);
    check("rst_exp", ex_exp_code, 0);
    check("rst_out", ex_out, 0);
    check("rst_pc", ex_pc, 0);

    reset = 1'b0;
    set_data(30'h1, 1'b0, 1'b1, 2'd0, 32'h0, 2'd0, 5'd1, 1'b0, 3'd0, 32'h1);
    tick();
    check("pass_pc", ex_pc, 1);
    check("pass_en_", ex_en_, 0);
    check("pass_br", ex_br_flag, 1);
    check("pass_dst", ex_dst_addr, 1);
    check("pass_we_", ex_gpr_we_, 0);
    check("pass_out", ex_out, 1);
    check("pass_exp", ex_exp_code, 0);

    stall = 1'b1; id_pc = 30'h2; alu_out = 32'h55; flush = 1'b1; alu_of = 1'b1;
    tick(3);
    check("stall_pc", ex_pc, 1);
    check("stall_out", ex_out, 1);
    stall = 1'b0; flush = 1'b0; alu_of = 1'b0;
    tick();
    check("resume_pc", ex_pc, 2);
    check("resume_out", ex_out, 32'h55);

    set_data(30'h20, 1'b0, 1'b0, 2'd1, 32'h1234, 2'd2, 5'd3, 1'b0, 3'd2, 32'h99);
    flush = 1'b1;
    tick();
    check("flush_en_", ex_en_, 1);
    check("flush_pc", ex_pc, 0);
    flush = 1'b0;
    tick();
    check("load_ctrl", ex_ctrl_op, 2);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_stall_pc", ex_pc, 30'h20);
    stall = 1'b0; flush = 1'b0;

    set_data(30'h10, 1'b0, 1'b1, 2'd2, 32'hdeadbeef, 2'd1, 5'd7, 1'b0, 3'd0, 32'h8000_0000);
    alu_of = 1'b1;
    tick();
    check("of_pc", ex_pc, 30'h10);
    check("of_mem_op", ex_mem_op, 0);
    check("of_we_", ex_gpr_we_, 1);
    check("of_dst", ex_dst_addr, 0);
    check("of_exp", ex_exp_code, 3);
    check("of_wd", ex_mem_wr_data, 0);

    int_detect = 1'b1;
    tick();
    check("int_of_exp", ex_exp_code, 1);
    check("int_of_br", ex_br_flag, 1);
    flush = 1'b1;
    tick();
    check("flush_int_exp", ex_exp_code, 0);
    check("flush_int_pc", ex_pc, 0);
    flush = 1'b0; int_detect = 1'b0; alu_of = 1'b0;

    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    check("rst_stall_pc", ex_pc, 0);
    check("rst_stall_en_", ex_en_, 1);
    reset = 1'b0; stall = 1'b0;
    tick();
    check("post_rst_pc", ex_pc, 30'h10);

    for (int i = 0; i < 200; i++) begin
      set_data($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      int_detect = ($urandom_range(0, 5) == 0);
      alu_of = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 15) == 0);
      tick();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0; int_detect = 1'b0; alu_of = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_reg.md
# ex_stage_reg

EX/MEM pipeline register of the 5-stage CPU (module name `ex_stage_reg`). It captures the ALU result and the control fields forwarded from the ID/EX register on each clock edge and presents them to the MEM stage. It supports pipeline stall (hold), flush (bubble insertion), and conversion of the current instruction into a bubble that carries an exception code on external interrupt or ALU overflow.

## Interface
- No parameters; widths come from the global config macros (`WORD_ADDR_W`=30, `WORD_DATA_W`=32, `REG_ADDR_W`=5, mem/ctrl op 2 bits, exception code 3 bits).
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- alu_out  in  32  ALU result of the instruction in EX
- alu_of  in  1  ALU signed overflow, active-high
- stall  in  1  hold all outputs, active-high
- flush  in  1  replace the stage content with a bubble, active-high
- int_detect  in  1  external interrupt detected, active-high
- id_pc  in  30  word PC of the instruction in EX
- id_en_  in  1  pipeline-data valid, active-low
- id_br_flag  in  1  branch flag
- id_mem_op  in  2  memory op (NOP=0, LDW=1, STW=2)
- id_mem_wr_data  in  32  store data
- id_ctrl_op  in  2  control op (NOP=0, WRCR=1, EXRT=2)
- id_dst_addr  in  5  GPR write address
- id_gpr_we_  in  1  GPR write enable, active-low
- id_exp_code  in  3  exception code (NO_EXP=0, EXT_INT=1, UNDEF_INSN=2, OVERFLOW=3, MISS_ALIGN=4, TRAP=5, PRV_VIO=6)
- ex_pc, ex_en_, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code  out  (same widths as id_* counterparts)  registered copies to MEM
- ex_out  out  32  registered ALU result

## Operation
Evaluated at every rising clk edge, highest priority first:
- reset=1: reset/bubble state — ex_pc=0, ex_en_=1 (invalid), ex_br_flag=0, ex_mem_op=NOP, ex_mem_wr_data=0, ex_ctrl_op=NOP, ex_dst_addr=0, ex_gpr_we_=1 (disabled), ex_exp_code=NO_EXP, ex_out=0.
- stall=1: every output holds its value (flush, int_detect and alu_of are ignored).
- flush=1: load the reset/bubble state.
- int_detect=1: ex_pc=id_pc, ex_en_=id_en_, ex_br_flag=id_br_flag; ex_mem_op=NOP, ex_ctrl_op=NOP, ex_dst_addr=0, ex_gpr_we_=1, ex_mem_wr_data=0, ex_out=0; ex_exp_code=EXT_INT.
- alu_of=1: same as the interrupt case, but ex_exp_code=OVERFLOW.
- otherwise: every ex_* output equals its id_* input, and ex_out=alu_out.
- The interrupt and overflow paths suppress memory access and the register write, but keep the PC so that EPC can be recorded.
- No arithmetic is performed; all fields are straight copies at equal widths.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1.
- Outputs are pure registers with no combinational path from input to output.
- Reset is synchronous. Asserting reset mid-stream clears the outputs at the next edge, even when stall=1. Release reset after one cycle; the next edge loads data normally.
- When inputs are applied exactly at an edge, the values present before the edge are the ones captured.
- Simultaneous flush and int_detect: flush wins. Simultaneous int_detect and alu_of: EXT_INT wins.
- Stalls of any length hold the outputs indefinitely. The cycle after stall drops, the register resumes with the then-current inputs.

## Test plan
- Reset: assert reset for one edge with arbitrary inputs -> all outputs at bubble values (ex_en_=1, ex_gpr_we_=1, ex_exp_code=0, ex_out=0).
- Normal pass-through: id_pc=0x01, id_en_=0, id_br_flag=1, id_dst_addr=1, id_gpr_we_=0, alu_out=0x01, mem/ctrl NOP -> after the next edge, ex_pc=0x01, ex_en_=0, ex_br_flag=1, ex_dst_addr=1, ex_gpr_we_=0, ex_out=0x01, ex_exp_code=0.
- Stall: after the pass-through, set stall=1 and change the inputs (id_pc=0x02, alu_out=0x55) for 3 edges -> outputs remain at the 0x01 values; drop stall -> ex_pc=0x02, ex_out=0x55 after the next edge.
- Flush: with valid inputs and flush=1 -> bubble values; then flush=1 together with stall=1 -> outputs hold.
- Overflow: id_mem_op=STW, id_gpr_we_=0, id_dst_addr=7, id_pc=0x10, alu_of=1 -> ex_pc=0x10, ex_mem_op=0, ex_gpr_we_=1, ex_dst_addr=0, ex_exp_code=3.
- Interrupt priority: int_detect=1 and alu_of=1 together -> ex_exp_code=1; flush=1 together with int_detect=1 -> bubble with ex_exp_code=0.
